// File: rtl/ped_xing_scheduler_pkg.sv
// ped_xing_pkg: shared types and constants for the pedestrian-crossing scheduler.
//   state_t     - phase enumeration, in service order
//   CNT_W       - phase timer width
//   *_D         - default phase durations in ticks
//   next_phase  - successor phase in the fixed service cycle
//   phase_load  - value loaded into the timer on entry to a phase (duration - 1)
package ped_xing_pkg;

  localparam int CNT_W       = 4;
  localparam int MIN_GREEN_D = 6;
  localparam int YELLOW_T_D  = 3;
  localparam int ALLRED_T_D  = 2;
  localparam int WALK_T_D    = 5;
  localparam int FLASH_T_D   = 4;

  typedef enum logic [2:0] {
    ST_GREEN   = 3'd0,
    ST_YELLOW  = 3'd1,
    ST_ALLRED1 = 3'd2,
    ST_WALK    = 3'd3,
    ST_FLASH   = 3'd4,
    ST_ALLRED2 = 3'd5
  } state_t;

  function automatic state_t next_phase(input state_t s);
    case (s)
      ST_GREEN:   return ST_YELLOW;
      ST_YELLOW:  return ST_ALLRED1;
      ST_ALLRED1: return ST_WALK;
      ST_WALK:    return ST_FLASH;
      ST_FLASH:   return ST_ALLRED2;
      default:    return ST_GREEN;
    endcase
  endfunction

  // Durations are passed in so the top-level parameters, not the package
  // defaults, decide the timing.
  function automatic logic [CNT_W-1:0] phase_load(input state_t s,
                                                  input int min_g,
                                                  input int yel,
                                                  input int allred,
                                                  input int wlk,
                                                  input int flsh);
    case (s)
      ST_GREEN:   return CNT_W'(min_g - 1);
      ST_YELLOW:  return CNT_W'(yel - 1);
      ST_WALK:    return CNT_W'(wlk - 1);
      ST_FLASH:   return CNT_W'(flsh - 1);
      default:    return CNT_W'(allred - 1);
    endcase
  endfunction

endpackage

// File: rtl/ped_xing_scheduler_if.sv
// ped_xing_scheduler_if: control inputs and lamp/display outputs of the
// crossing scheduler.
//   master - controller side (drives tick, ped_req; observes lamps)
//   slave  - scheduler side
interface ped_xing_scheduler_if;
  import ped_xing_pkg::*;

  logic             tick;
  logic             ped_req;
  logic             car_green;
  logic             car_yellow;
  logic             car_red;
  logic             walk;
  logic             dont_walk;
  logic [CNT_W-1:0] countdown;
  logic             req_pending;

  modport master (
    output tick, ped_req,
    input  car_green, car_yellow, car_red, walk, dont_walk, countdown, req_pending
  );

  modport slave (
    input  tick, ped_req,
    output car_green, car_yellow, car_red, walk, dont_walk, countdown, req_pending
  );

endinterface

// File: rtl/ped_xing_scheduler_phase_timer.sv
// phase_timer: loadable down-counter for phase timing.
//   i_load/i_load_val - synchronous load (wins over tick)
//   i_tick            - decrement enable; the count saturates at zero
//   o_cnt, o_zero     - current count and terminal-count flag
module phase_timer
  import ped_xing_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ped_xing_scheduler.sv
// ped_xing_scheduler: car/pedestrian phase sequencer for one crosswalk.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - ped_xing_scheduler_if.slave (tick, ped_req in; lamps,
//                countdown, req_pending out)
// Optional macro PED_SYNC_EN: adds a 2-flop synchroniser on ped_req.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_GREEN   | cars go; leaves only after MIN_GREEN and a request
// ST_YELLOW  | cars warned
// ST_ALLRED1 | clearance before walk
// ST_WALK    | pedestrians cross (request latch cleared on entry)
// ST_FLASH   | flashing don't-walk
// ST_ALLRED2 | clearance before car green
module ped_xing_scheduler
  import ped_xing_pkg::*;
#(
  parameter int MIN_GREEN = MIN_GREEN_D,
  parameter int YELLOW_T  = YELLOW_T_D,
  parameter int ALLRED_T  = ALLRED_T_D,
  parameter int WALK_T    = WALK_T_D,
  parameter int FLASH_T   = FLASH_T_D
) (
  input  logic             clk,
  input  logic             rst_n,
  ped_xing_scheduler_if.slave bus
);

  state_t           r_state;
  logic             r_req;
  logic             r_flash;
  logic             r_car_green;
  logic             r_car_yellow;
  logic             r_car_red;
  logic             r_walk;
  logic             r_dont_walk;
  logic             w_ped;
  logic             w_zero;
  logic             w_adv;
  state_t           w_next;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_load_val;

`ifdef PED_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], bus.ped_req};
    end
  end

  assign w_ped = r_sync[1];
`else
  assign w_ped = bus.ped_req;
`endif

  // GREEN holds at zero until a request is latched; every other phase
  // advances on the tick that finds the timer at zero.
  assign w_next     = next_phase(r_state);
  assign w_adv      = bus.tick && w_zero && ((r_state != ST_GREEN) || r_req);
  assign w_load_val = phase_load(w_next, MIN_GREEN, YELLOW_T, ALLRED_T, WALK_T, FLASH_T);

  phase_timer #(
    .RST_VAL (CNT_W'(MIN_GREEN - 1))
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_adv),
    .i_load_val (w_load_val),
    .i_tick     (bus.tick),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  // Lamps are registered alongside the state so they decode the new phase
  // on the same edge that enters it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_GREEN;
      r_req        <= 1'b0;
      r_flash      <= 1'b0;
      r_car_green  <= 1'b1;
      r_car_yellow <= 1'b0;
      r_car_red    <= 1'b0;
      r_walk       <= 1'b0;
      r_dont_walk  <= 1'b1;
    end else begin
      // Clearing on WALK entry beats a press in the same cycle.
      if (w_adv && (w_next == ST_WALK)) begin
        r_req <= 1'b0;
      end else if (w_ped) begin
        r_req <= 1'b1;
      end

      if (w_adv) begin
        r_state      <= w_next;
        r_flash      <= (w_next == ST_FLASH);
        r_car_green  <= (w_next == ST_GREEN);
        r_car_yellow <= (w_next == ST_YELLOW);
        r_car_red    <= (w_next != ST_GREEN) && (w_next != ST_YELLOW);
        r_walk       <= (w_next == ST_WALK);
        r_dont_walk  <= (w_next != ST_WALK);
      end else if (bus.tick && (r_state == ST_FLASH)) begin
        r_flash     <= ~r_flash;
        r_dont_walk <= ~r_flash;
      end
    end
  end

  assign bus.car_green   = r_car_green;
  assign bus.car_yellow  = r_car_yellow;
  assign bus.car_red     = r_car_red;
  assign bus.walk        = r_walk;
  assign bus.dont_walk   = r_dont_walk;
  assign bus.countdown   = w_cnt;
  assign bus.req_pending = r_req;

endmodule

// File: tb/tb_ped_xing_scheduler.sv
module tb_ped_xing_scheduler;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ped_xing_scheduler_if bus ();

  ped_xing_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase index 0..5 in service order, ticks remaining.
  int dur [6] = '{6, 3, 2, 5, 4, 2};
  int m_ph;
  int m_rem;
  bit m_req;
  bit m_fl;
  bit m_p1;
  bit m_p2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_rem = dur[0] - 1; m_req = 0; m_fl = 0; m_p1 = 0; m_p2 = 0;
  endtask

  task automatic model_step(input bit t, input bit p);
    bit eff;
    bit entered_walk;
`ifdef PED_SYNC_EN
    eff  = m_p2;
    m_p2 = m_p1;
    m_p1 = p;
`else
    eff = p;
`endif
    entered_walk = 0;
    if (t) begin
      if (m_rem > 0) begin
        m_rem--;
        if (m_ph == 4) m_fl = !m_fl;
      end else if (m_ph != 0 || m_req) begin
        m_ph  = (m_ph + 1) % 6;
        m_rem = dur[m_ph] - 1;
        if (m_ph == 4) m_fl = 1;
        if (m_ph == 3) entered_walk = 1;
      end
    end
    if (entered_walk) m_req = 0;
    else if (eff) m_req = 1;
  endtask

  task automatic compare_all(input string tag);
    logic [9:0] got, exp;
    got = {bus.car_green, bus.car_yellow, bus.car_red, bus.walk, bus.dont_walk,
           bus.countdown, bus.req_pending};
    exp = {m_ph == 0, m_ph == 1, m_ph >= 2, m_ph == 3,
           (m_ph == 3) ? 1'b0 : ((m_ph == 4) ? m_fl : 1'b1),
           4'(m_rem), m_req};
    chk(tag, 32'(got), 32'(exp));
    chk("lamp_rules", 32'($onehot({bus.car_green, bus.car_yellow, bus.car_red}) &&
                            !(bus.walk && (bus.car_green || bus.car_yellow))), 32'd1);
  endtask

  task automatic step(input bit t, input bit p, input string tag);
    bus.tick    = t;
    bus.ped_req = p;
    @(posedge clk);
    model_step(t, p);
    #1;
    compare_all(tag);
  endtask

  initial begin
    int lat;
    bit seen;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.tick = 1'b0;
    bus.ped_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    #3 rst_n = 1'b1;

    // Idle: green holds, countdown runs to 0 and stays there.
    for (int i = 0; i < 40; i++) step(1, 0, "idle");
    chk("idle_cnt0", 32'(bus.countdown), 32'd0);
    chk("idle_green", 32'(bus.car_green), 32'd1);

    // Request right after a fresh reset, full cycle at tick-every-cycle.
    rst_n = 1'b0; #2; model_reset(); #1;
    compare_all("reset2");
    rst_n = 1'b1;
    step(1, 1, "req_at_reset");
    for (int i = 0; i < 30; i++) step(1, 0, "cycle");

    // Late press after green has expired, then a press during WALK.
    for (int i = 0; i < 10; i++) step(1, 0, "late_wait");
    step(1, 1, "late_press");
    for (int i = 0; i < 60; i++) step(1, (m_ph == 3 && i % 3 == 0), "walk_press");

    // Random ticks and presses.
    for (int i = 0; i < 400; i++)
      step($urandom_range(1, 0) == 1, $urandom_range(9, 0) == 0, "rand");

    // Sparse ticks every 7 clocks.
    for (int i = 0; i < 600; i++)
      step((i % 7) == 0, $urandom_range(19, 0) == 0, "sparse");

    // Drive to FLASH, then reset asynchronously mid-phase.
    step(1, 1, "to_flash_press");
    for (int i = 0; i < 100 && m_ph != 4; i++) step(1, 0, "to_flash");
    chk("reached_flash", 32'(m_ph), 32'd4);
    step(1, 1, "flash_press");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    chk("async_cd", 32'(bus.countdown), 32'd5);
    chk("async_req", 32'(bus.req_pending), 32'd0);
    #3 rst_n = 1'b1;

    // Press-to-latch latency in clk edges.
    step(0, 1, "lat_press");
    lat = 1;
    seen = bus.req_pending;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(0, 0, "lat_wait");
      lat++;
      seen = bus.req_pending;
    end
    chk("lat_seen", 32'(seen), 32'd1);
`ifdef PED_SYNC_EN
    chk("latency", 32'(lat), 32'd3);
`else
    chk("latency", 32'(lat), 32'd1);
`endif
    for (int i = 0; i < 40; i++) step(1, 0, "drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
